// File: rtl/step2_ctrl_if.sv
// Control bundle between the step-2 sequencer and its datapath / neighbours.
// master = controller side, slave = environment / datapath side.
interface step2_ctrl_if #(
    parameter int unsigned OUT_AW = 8
);
    logic              start;
    logic              data_ready;
    logic              s2_ready;
    logic [1:0]        RF2_Data_sel;
    logic              RF2_EN;
    logic [3:0]        RF2_Address_W;
    logic [3:0]        RF2_Address_R;
    logic [6:0]        vec_addr;
    logic              clear_2;
    logic              RF2_new_val;
    logic [7:0]        Dot_Select;
    logic [2:0]        out_select;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;
    logic              done;

    modport master (
        input  start, data_ready,
        output s2_ready, RF2_Data_sel, RF2_EN, RF2_Address_W, RF2_Address_R,
               vec_addr, clear_2, RF2_new_val, Dot_Select, out_select,
               out_we, out_addr, done
    );

    modport slave (
        output start, data_ready,
        input  s2_ready, RF2_Data_sel, RF2_EN, RF2_Address_W, RF2_Address_R,
               vec_addr, clear_2, RF2_new_val, Dot_Select, out_select,
               out_we, out_addr, done
    );
endinterface

// File: rtl/step2_ctrl.sv
// Step-2 sequencer: loads four z groups into RF2, sweeps 8x16 filter elements
// through the dot units, then streams the eight dot results to output memory.
module step2_ctrl #(
    parameter int unsigned       OUT_AW   = 8,
    parameter logic [OUT_AW-1:0] OUT_BASE = 8'h00
) (
    input  logic         clock,
    input  logic         reset_n,
    step2_ctrl_if.master bus
);

    localparam int unsigned WCNT_W   = 4;
    localparam int unsigned VEC_W    = 7;
    localparam logic [VEC_W-1:0]  VEC_LAST   = 7'd127;
    localparam logic [WCNT_W-1:0] WCNT_LAST  = 4'd8;
    localparam logic [WCNT_W-1:0] WSEL_LAST  = 4'd7;

    typedef enum logic [2:0] {
        IDLE, WAIT_Z, LOAD, CLEAR, COMP, DRAIN, WRITE, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          g_q, g_d;
    logic [1:0]          j_q, j_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic                s2_ready_q, s2_ready_d;
    logic                rf2_en_q, rf2_en_d;
    logic                clear_q, clear_d;
    logic                new_val_q, new_val_d;
    logic                out_we_q, out_we_d;
    logic                done_q, done_d;
    logic [1:0]          data_sel_q, data_sel_d;
    logic [3:0]          addr_w_q, addr_w_d;
    logic [3:0]          addr_r_q, addr_r_d;
    logic [VEC_W-1:0]    vec_addr_q, vec_addr_d;
    logic [7:0]          dot_sel_q, dot_sel_d;
    logic [2:0]          out_sel_q, out_sel_d;
    logic [OUT_AW-1:0]   out_addr_q, out_addr_d;

    // Next-state and next-output computation; every output is a register.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        j_d         = j_q;
        wcnt_d      = wcnt_q;
        s2_ready_d  = 1'b0;
        rf2_en_d    = 1'b0;
        clear_d     = 1'b0;
        new_val_d   = 1'b0;
        out_we_d    = 1'b0;
        done_d      = 1'b0;
        data_sel_d  = data_sel_q;
        addr_w_d    = addr_w_q;
        addr_r_d    = addr_r_q;
        vec_addr_d  = vec_addr_q;
        dot_sel_d   = 8'hFF;
        out_sel_d   = out_sel_q;
        out_addr_d  = out_we_q ? OUT_AW'(out_addr_q + OUT_AW'(1)) : out_addr_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = WAIT_Z;
                    g_d        = 2'd0;
                    s2_ready_d = 1'b1;
                end
            end
            WAIT_Z: begin
                if (bus.data_ready) begin
                    state_d    = LOAD;
                    j_d        = 2'd0;
                    rf2_en_d   = 1'b1;
                    data_sel_d = 2'd0;
                    addr_w_d   = {g_q, 2'd0};
                end else begin
                    s2_ready_d = 1'b1;
                end
            end
            LOAD: begin
                if (j_q == 2'd3) begin
                    g_d = 2'(g_q + 2'd1);
                    if (g_q == 2'd3) begin
                        state_d = CLEAR;
                        clear_d = 1'b1;
                    end else begin
                        state_d    = WAIT_Z;
                        s2_ready_d = 1'b1;
                    end
                end else begin
                    j_d        = 2'(j_q + 2'd1);
                    rf2_en_d   = 1'b1;
                    data_sel_d = 2'(j_q + 2'd1);
                    addr_w_d   = {g_q, 2'(j_q + 2'd1)};
                end
            end
            CLEAR: begin
                state_d    = COMP;
                vec_addr_d = '0;
            end
            COMP: begin
                // Filter data arrives one cycle after its address, so the
                // accumulate controls are this cycle's address registered.
                new_val_d = 1'b1;
                addr_r_d  = vec_addr_q[3:0];
                dot_sel_d = 8'(~(8'b1 << vec_addr_q[6:4]));
                if (vec_addr_q == VEC_LAST) begin
                    state_d = DRAIN;
                end else begin
                    vec_addr_d = VEC_W'(vec_addr_q + VEC_W'(1));
                end
            end
            DRAIN: begin
                state_d   = WRITE;
                wcnt_d    = '0;
                out_sel_d = 3'd0;
            end
            WRITE: begin
                // Output register adds a cycle: write n lands one cycle after select n.
                if (wcnt_q == WCNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    wcnt_d   = WCNT_W'(wcnt_q + WCNT_W'(1));
                    out_we_d = 1'b1;
                    if (wcnt_q < WSEL_LAST) begin
                        out_sel_d = 3'(wcnt_q[2:0] + 3'd1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            j_q        <= '0;
            wcnt_q     <= '0;
            s2_ready_q <= 1'b0;
            rf2_en_q   <= 1'b0;
            clear_q    <= 1'b0;
            new_val_q  <= 1'b0;
            out_we_q   <= 1'b0;
            done_q     <= 1'b0;
            data_sel_q <= '0;
            addr_w_q   <= '0;
            addr_r_q   <= '0;
            vec_addr_q <= '0;
            dot_sel_q  <= 8'hFF;
            out_sel_q  <= '0;
            out_addr_q <= OUT_BASE;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            j_q        <= j_d;
            wcnt_q     <= wcnt_d;
            s2_ready_q <= s2_ready_d;
            rf2_en_q   <= rf2_en_d;
            clear_q    <= clear_d;
            new_val_q  <= new_val_d;
            out_we_q   <= out_we_d;
            done_q     <= done_d;
            data_sel_q <= data_sel_d;
            addr_w_q   <= addr_w_d;
            addr_r_q   <= addr_r_d;
            vec_addr_q <= vec_addr_d;
            dot_sel_q  <= dot_sel_d;
            out_sel_q  <= out_sel_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign bus.s2_ready      = s2_ready_q;
    assign bus.RF2_EN        = rf2_en_q;
    assign bus.clear_2       = clear_q;
    assign bus.RF2_new_val   = new_val_q;
    assign bus.out_we        = out_we_q;
    assign bus.done          = done_q;
    assign bus.RF2_Data_sel  = data_sel_q;
    assign bus.RF2_Address_W = addr_w_q;
    assign bus.RF2_Address_R = addr_r_q;
    assign bus.vec_addr      = vec_addr_q;
    assign bus.Dot_Select    = dot_sel_q;
    assign bus.out_select    = out_sel_q;
    assign bus.out_addr      = out_addr_q;

endmodule

// File: tb/tb_step2_ctrl.sv
// Self-checking bench for step2_ctrl: scoreboarded load/compute/write sequences
// plus a behavioural datapath (RF2, filter memory, dot units, output memory).
module tb_step2_ctrl;

    logic clock;
    logic reset_n;

    step2_ctrl_if #(.OUT_AW(8)) bus ();

    step2_ctrl #(.OUT_AW(8), .OUT_BASE(8'h00)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed { logic [3:0] addr; logic [1:0] sel; } ld_t;
    typedef struct packed { logic [3:0] addr; logic [7:0] dsel; } cp_t;
    typedef struct packed { logic [7:0] addr; logic [2:0] sel; } wr_t;

    ld_t lq[$];
    cp_t cq[$];
    wr_t wq[$];

    int total = 0;
    int bad   = 0;
    int exp_base = 0;
    int last_base = 0;
    int frame_id = 0;

    localparam logic [41:0] RST_VEC = {6'b0, 2'd0, 4'd0, 4'd0, 7'd0, 3'd0, 8'hFF, 8'h00};

    // Behavioural datapath: z values all 1, filter f elements all f+1.
    int rf2 [16];
    int fdata;
    int dot [8];
    int out_reg;
    int omem_val [256];
    int omem_tag [256];

    always @(posedge clock) begin
        if (bus.RF2_EN) rf2[bus.RF2_Address_W] <= 1;
        fdata <= int'(bus.vec_addr[6:4]) + 1;
        for (int i = 0; i < 8; i++) begin
            if (bus.clear_2) dot[i] <= 0;
            else if (bus.RF2_new_val && !bus.Dot_Select[i])
                dot[i] <= dot[i] + rf2[bus.RF2_Address_R] * fdata;
        end
        out_reg <= dot[bus.out_select];
        if (bus.out_we) begin
            omem_val[bus.out_addr] <= out_reg;
            omem_tag[bus.out_addr] <= frame_id;
        end
    end

    function automatic logic [41:0] out_vec();
        return {bus.s2_ready, bus.RF2_EN, bus.clear_2, bus.RF2_new_val, bus.out_we, bus.done,
                bus.RF2_Data_sel, bus.RF2_Address_W, bus.RF2_Address_R, bus.vec_addr,
                bus.out_select, bus.Dot_Select, bus.out_addr};
    endfunction

    // Drives one frame, scoreboarding every RF2 write, accumulate and output write.
    // cycles counts the start cycle as 1 and the done cycle inclusive.
    task automatic run_frame(input int spacing, input bit b2b, input bit stray_ld,
                             input bit stray_start, input int abort_at,
                             output int cycles, output bit aborted);
        int cnt, accepted, gap;
        bit seen_done, s2p, stray_done;
        logic [6:0] pv;
        logic [2:0] ps;
        logic [7:0] dexp;
        ld_t le; cp_t ce; wr_t we;
        frame_id++;
        for (int g = 0; g < 4; g++)
            for (int j = 0; j < 4; j++) lq.push_back('{addr: 4'(g * 4 + j), sel: 2'(j)});
        for (int v = 0; v < 128; v++) begin
            dexp = 8'b1 << (v / 16);
            cq.push_back('{addr: 4'(v % 16), dsel: ~dexp});
        end
        for (int i = 0; i < 8; i++) wq.push_back('{addr: 8'(exp_base + i), sel: 3'(i)});

        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.data_ready = b2b;
        cnt = 1; accepted = 0; gap = 0; seen_done = 0; stray_done = 0; aborted = 0;
        pv = bus.vec_addr; ps = bus.out_select; s2p = bus.s2_ready;
        while (!seen_done && cnt < 3000) begin
            @(posedge clock); #1;
            cnt++;
            if (bus.RF2_EN) begin
                total++;
                if (lq.size() == 0) begin
                    bad++; $display("FAIL load_extra: RF2_EN at cycle %0d addr=%0d, required no write", cnt, bus.RF2_Address_W);
                end else begin
                    le = lq.pop_front();
                    if ({bus.RF2_Address_W, bus.RF2_Data_sel} !== {le.addr, le.sel}) begin
                        bad++; $display("FAIL load_order: addr/sel=%0d/%0d required %0d/%0d", bus.RF2_Address_W, bus.RF2_Data_sel, le.addr, le.sel);
                    end
                end
                total++;
                if (bus.s2_ready !== 1'b0) begin
                    bad++; $display("FAIL load_s2_ready: s2_ready=%b required 0", bus.s2_ready);
                end
            end
            if (bus.RF2_new_val) begin
                dexp = ~(8'b1 << pv[6:4]);
                total++;
                if ({bus.RF2_Address_R, bus.Dot_Select} !== {pv[3:0], dexp}) begin
                    bad++; $display("FAIL comp_prev: addr_r/dsel=%0d/%h required %0d/%h", bus.RF2_Address_R, bus.Dot_Select, pv[3:0], dexp);
                end
                total++;
                if (cq.size() == 0) begin
                    bad++; $display("FAIL comp_extra: RF2_new_val at cycle %0d, required 0", cnt);
                end else begin
                    ce = cq.pop_front();
                    if ({bus.RF2_Address_R, bus.Dot_Select} !== {ce.addr, ce.dsel}) begin
                        bad++; $display("FAIL comp_seq: addr_r/dsel=%0d/%h required %0d/%h", bus.RF2_Address_R, bus.Dot_Select, ce.addr, ce.dsel);
                    end
                end
            end
            if (bus.out_we) begin
                total++;
                if (wq.size() == 0) begin
                    bad++; $display("FAIL write_extra: out_we at cycle %0d, required 0", cnt);
                end else begin
                    we = wq.pop_front();
                    if ({bus.out_addr, ps} !== {we.addr, we.sel}) begin
                        bad++; $display("FAIL write_seq: addr/prev_sel=%0d/%0d required %0d/%0d", bus.out_addr, ps, we.addr, we.sel);
                    end
                end
            end
            pv = bus.vec_addr;
            ps = bus.out_select;
            if (bus.done) seen_done = 1;
            if (abort_at == cnt) begin
                #2 reset_n = 1'b0;
                #1 aborted = 1;
                break;
            end
            bus.start = stray_start && (cnt == 60 || cnt == 155);
            if (bus.data_ready && s2p) accepted++;
            s2p = bus.s2_ready;
            if (b2b) begin
                bus.data_ready = (accepted < 4);
            end else begin
                bus.data_ready = 1'b0;
                if (gap > 0) gap--;
                else if (accepted < 4 && bus.s2_ready) begin
                    bus.data_ready = 1'b1;
                    gap = spacing;
                end
                if (stray_ld && !stray_done && accepted == 1 && gap == spacing - 2) begin
                    bus.data_ready = 1'b1;
                    stray_done = 1;
                    total++;
                    if (bus.s2_ready !== 1'b0) begin
                        bad++; $display("FAIL stray_in_load: s2_ready=%b required 0", bus.s2_ready);
                    end
                end
            end
        end
        bus.start = 1'b0;
        bus.data_ready = 1'b0;
        cycles = cnt;
        if (!aborted) begin
            total++;
            if (!seen_done) begin
                bad++; $display("FAIL done_timeout: no done within %0d cycles", cnt);
            end
            total++;
            if ((lq.size() + cq.size() + wq.size()) != 0) begin
                bad++; $display("FAIL sb_leftover: %0d/%0d/%0d entries left, required 0/0/0", lq.size(), cq.size(), wq.size());
            end
            last_base = exp_base;
            exp_base = (exp_base + 8) % 256;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.data_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (out_vec() !== RST_VEC) begin
            bad++; $display("FAIL reset_values: outputs=%h required %h", out_vec(), RST_VEC);
        end
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        total++;
        if (out_vec() !== RST_VEC) begin
            bad++; $display("FAIL idle_hold: outputs=%h required %h", out_vec(), RST_VEC);
        end
    endtask

    task automatic test_load_order();
        int cyc; bit ab;
        run_frame(10, 1'b0, 1'b1, 1'b0, 0, cyc, ab);
    endtask

    task automatic test_compute();
        int cyc; bit ab;
        run_frame(0, 1'b1, 1'b0, 1'b0, 0, cyc, ab);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dot[i] != 16 * (i + 1)) begin
                bad++; $display("FAIL dot_result[%0d]: got %0d required %0d", i, dot[i], 16 * (i + 1));
            end
        end
    endtask

    task automatic test_output();
        int cyc; bit ab;
        run_frame(0, 1'b1, 1'b0, 1'b0, 0, cyc, ab);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (omem_val[last_base + i] != 16 * (i + 1) || omem_tag[last_base + i] != frame_id) begin
                bad++; $display("FAIL out_data[%0d]: value=%0d tag=%0d required %0d tag %0d", last_base + i,
                                omem_val[last_base + i], omem_tag[last_base + i], 16 * (i + 1), frame_id);
            end
        end
        @(posedge clock); #1;
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ab;
        for (int n = 0; n < 2; n++) begin
            run_frame(0, 1'b1, 1'b0, 1'b0, 0, cyc, ab);
            total++;
            if (cyc != 161) begin
                bad++; $display("FAIL frame_cycles[%0d]: got %0d required 161", n, cyc);
            end
        end
    endtask

    task automatic test_mid_comp_reset();
        int cyc; bit ab;
        // COMP starts at cycle index 22 (counted from 1 = start cycle 0 -> 23); cycle 50 of COMP -> 73.
        run_frame(0, 1'b1, 1'b0, 1'b0, 73, cyc, ab);
        total++;
        if (!ab || out_vec() !== RST_VEC) begin
            bad++; $display("FAIL async_reset: aborted=%0d outputs=%h required %h", ab, out_vec(), RST_VEC);
        end
        lq.delete(); cq.delete(); wq.delete();
        exp_base = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        run_frame(0, 1'b1, 1'b0, 1'b0, 0, cyc, ab);
        total++;
        if (cyc != 161) begin
            bad++; $display("FAIL post_reset_cycles: got %0d required 161", cyc);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (omem_val[i] != 16 * (i + 1) || omem_tag[i] != frame_id) begin
                bad++; $display("FAIL post_reset_data[%0d]: value=%0d tag=%0d required %0d tag %0d", i,
                                omem_val[i], omem_tag[i], 16 * (i + 1), frame_id);
            end
        end
    endtask

    task automatic test_stray_start();
        int cyc; bit ab;
        run_frame(0, 1'b1, 1'b0, 1'b1, 0, cyc, ab);
        total++;
        if (cyc != 161) begin
            bad++; $display("FAIL stray_start_cycles: got %0d required 161", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_load_order();
        test_compute();
        test_output();
        test_back_to_back();
        test_mid_comp_reset();
        test_stray_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step2_ctrl.md
# step2_ctrl

Sequencing controller for the step-2 datapath: the input capture register/RF2 data mux, the 16-entry RF2 register file, the eight dot-product units and the output register feeding output data memory. It accepts four groups of step-1 results (z0..z3), loads them into RF2 and clears the dot units. It then walks eight filters of 16 elements each through filter memory, and streams the eight dot results to output memory. It sits between the step-1 controller (upstream handshake) and the top-level sequencer (start/done).

## Interface
- OUT_BASE, 8'h00: first output-memory word address after reset
- OUT_AW, 8: output-memory address width

- clock  in  1  single system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame from IDLE, ignored otherwise
- data_ready  in  1  step-1 z0..z3 valid this cycle; accepted only when s2_ready=1
- s2_ready  out  1  controller can accept a z group
- RF2_Data_sel  out  2  selects z0..z3 into RF2
- RF2_EN  out  1  RF2 write enable
- RF2_Address_W  out  4  RF2 write address
- RF2_Address_R  out  4  RF2 read address
- vec_addr  out  7  filter-memory read address {filter[2:0], elem[3:0]}
- clear_2  out  1  clears all dot accumulators
- RF2_new_val  out  1  dot units accumulate this cycle
- Dot_Select  out  8  per-unit hold; 0 = unit accumulates, 1 = holds
- out_select  out  3  output-register mux select
- out_we  out  1  output-memory write enable
- out_addr  out  OUT_AW  output-memory write address
- done  out  1  one-cycle pulse at frame completion

## Operation
- Reset values: state IDLE; s2_ready, RF2_EN, clear_2, RF2_new_val, out_we, done = 0; RF2_Data_sel, RF2_Address_W, RF2_Address_R, vec_addr, out_select = 0; Dot_Select = 8'hFF; out_addr = OUT_BASE.
- States: IDLE, WAIT_Z, LOAD, CLEAR, COMP, DRAIN, WRITE, DONE.
- IDLE: start -> WAIT_Z, group count g=0.
- WAIT_Z: s2_ready=1. data_ready -> LOAD, j=0. The input register captures z0..z3 on the same edge.
- LOAD: 4 cycles, j=0..3. RF2_EN=1, RF2_Data_sel=j, RF2_Address_W={g[1:0],j[1:0]}, s2_ready=0.
  - After j=3: g increments. If g was 3 -> CLEAR, else -> WAIT_Z.
  - data_ready while s2_ready=0 is ignored; upstream must hold or re-pulse.
- CLEAR: 1 cycle, clear_2=1, Dot_Select=8'hFF; f=0, k=0 -> COMP.
- COMP: 128 cycles. Each cycle issues vec_addr={f,k}; k increments, and on wrap f increments. After f=7,k=15 -> DRAIN.
- Filter memory read has 1-cycle latency, so the accumulate controls are the address registered one cycle later:
  - RF2_Address_R = previous k
  - Dot_Select = ~(8'b1 << previous f)
  - RF2_new_val = 1
- DRAIN: 1 cycle; applies the final (f=7,k=15) accumulate; vec_addr held.
- WRITE: out_select steps 0..7 over 8 cycles. The output register adds 1 cycle, so out_we is issued one cycle after each select, for 8 writes over 9 cycles.
  - out_addr increments after each write, wrapping modulo 2^OUT_AW.
  - out_addr is not reset between frames; frame n writes OUT_BASE+8n..+8n+7.
- DONE: done=1 for 1 cycle -> IDLE.
- Dot_Select=8'hFF and RF2_new_val=0 in every state except the accumulate cycles above.
- start while not IDLE: ignored.
- reset_n low at any point, including mid-LOAD or mid-COMP: immediately returns all outputs to reset values. Partially loaded RF2 contents are abandoned; the next frame rewrites all 16 entries.

## Timing
- Start-to-first-s2_ready: 1 cycle.
- Each z group: 1 accept cycle + 4 LOAD cycles. Back-to-back data_ready gives 20 cycles for 4 groups.
- CLEAR 1 + COMP 128 + DRAIN 1 = 130 cycles.
- RF2_new_val is high on 128 consecutive cycles, starting the cycle after the first COMP cycle.
- WRITE 9 cycles, then DONE 1 cycle.
- Minimum frame: start -> done = 1 + 20 + 130 + 9 + 1 = 161 cycles.
- All outputs are registered (Moore); no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset_n=0 for 3 cycles -> every output at its reset value, out_addr=OUT_BASE; release with no start -> state stays IDLE, s2_ready=0.
- Load order: start, then 4 data_ready pulses spaced 10 cycles apart -> 16 RF2_EN cycles with addresses 0..15 and Data_sel cycling 0,1,2,3; s2_ready=0 during every LOAD; an extra data_ready during LOAD is ignored.
- Compute sweep: check 128 RF2_new_val cycles, each with RF2_Address_R = vec_addr[3:0] of the prior cycle and Dot_Select one-hot-low matching vec_addr[6:4] of the prior cycle. With RF2 = 1 and filters = f+1, the final dot outputs are 16, 32, ..., 128.
- Output: out_we pulses 8 times, addresses OUT_BASE..OUT_BASE+7, data order O0..O7; a second frame writes +8..+15; done occurs exactly 161 cycles after start with back-to-back data_ready.
- Mid-COMP reset: assert reset_n=0 at COMP cycle 50 -> outputs return to reset values asynchronously; a following full frame behaves identically to a fresh frame.
- Stray start: pulse start during COMP and WRITE -> no effect on sequence or cycle count.
